sw_debounce: RTL

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce.sv | 77 +++++++
 1 files changed

// File: rtl/sw_debounce.sv
// Per-bit switch synchronizer and debouncer: sw_db follows sw after DB_CYCLES stable cycles.
// Compile-time option: define SW_SYNC3_EN to add a third synchronizer stage.
module sw_debounce #(
    parameter int N         = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw,
    output logic [N-1:0] sw_db,
    output logic         changed
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [N-1:0]  sync1;
    logic [N-1:0]  sync2;
    logic [N-1:0]  db_in;
    logic [N-1:0]  upd;
    logic [N-1:0]  sw_db_nxt;
    logic [CW-1:0] cnt     [N];
    logic [CW-1:0] cnt_nxt [N];

`ifdef SW_SYNC3_EN
    logic [N-1:0] sync3;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync3 <= '0;
        end else begin
            sync3 <= sync2;
        end
    end

    assign db_in = sync3;
`else
    assign db_in = sync2;
`endif

    // A mismatch that survives DB_CYCLES consecutive edges commits; any match restarts the count.
    always_comb begin
        upd = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cnt_nxt[i] = '0;
            if (db_in[i] != sw_db[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    upd[i] = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
        sw_db_nxt = (sw_db & ~upd) | (db_in & upd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            sw_db   <= '0;
            changed <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1   <= sw;
            sync2   <= sync1;
            sw_db   <= sw_db_nxt;
            changed <= |upd;
            for (int unsigned i = 0; i < N; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule
